// File: rtl/calc_display.sv
// Display stage for the calculator core: captures the serial digit stream into a
// shadow bank, commits on entry to ready, and scans eight common-anode digits.
`timescale 1ns/1ps
module calc_display #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       frame_done,
    output logic       err
);
    localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [1:0] ST_ERRCODE = 2'b00;
    localparam logic [1:0] ST_BUSY    = 2'b01;
    localparam logic [1:0] ST_READY   = 2'b10;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_E      = 7'b0000110;
    localparam logic [6:0] SEG_R      = 7'b0101111;
    localparam logic [6:0] SEG_O      = 7'b0100011;

    typedef enum logic {ST_NORMAL, ST_ERROR} state_t;

    state_t         state, state_next;
    logic [1:0]     prev_status;
    logic [CW-1:0]  cnt;
    logic [2:0]     idx;
    logic [3:0]     shadow [8];
    logic [3:0]     disp   [8];
    logic           tick_c, capture_c, commit_c;
    logic           zero_run;
    logic [7:0]     lz_blank;
    logic [6:0]     seg_nxt;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = SEG_BLANK;
        endcase
    endfunction

    // Next state plus capture/commit strobes; error is terminal until reset.
    always_comb begin
        state_next = state;
        capture_c  = 1'b0;
        commit_c   = 1'b0;
        tick_c     = (cnt == CW'(PRESCALE - 1));
        if (state == ST_NORMAL) begin
            capture_c = (status == ST_BUSY) && !pos[3];
            commit_c  = (status == ST_READY) && (prev_status != ST_READY);
            if (status == ST_ERRCODE) state_next = ST_ERROR;
        end
    end

    // Leading-zero mask: a digit blanks when it and everything above it is zero.
    always_comb begin
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = 7; i >= 0; i--) begin
            zero_run    = zero_run && (disp[i] == 4'd0);
            lz_blank[i] = (BLANK_LZ != 0) && zero_run && (i != 0);
        end
    end

    always_comb begin
        seg_nxt = SEG_BLANK;
        if (err) begin
            case (idx)
                3'd0:       seg_nxt = SEG_O;
                3'd1, 3'd2: seg_nxt = SEG_R;
                3'd3:       seg_nxt = SEG_E;
                default:    seg_nxt = SEG_BLANK;
            endcase
        end else if (!lz_blank[idx]) begin
            seg_nxt = decode(disp[idx]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_NORMAL;
            err         <= 1'b0;
            prev_status <= ST_BUSY;
            cnt         <= '0;
            idx         <= '0;
            frame_done  <= 1'b0;
            an          <= 8'hFF;
            seg         <= SEG_BLANK;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= '0;
                disp[i]   <= '0;
            end
        end else begin
            state       <= state_next;
            err         <= (state_next == ST_ERROR);
            prev_status <= status;
            cnt         <= tick_c ? '0 : cnt + CW'(1);
            if (tick_c) idx <= idx + 3'd1;
            frame_done  <= tick_c && (idx == 3'd7);
            an          <= ~(8'd1 << idx);
            seg         <= seg_nxt;
            if (capture_c) shadow[pos[2:0]] <= data;
            if (commit_c) begin
                for (int i = 0; i < 8; i++) disp[i] <= shadow[i];
            end
        end
    end
endmodule

// File: tb/tb_calc_display.sv
// Scoreboard bench for calc_display: two instances (blanking on/off) share stimulus.
`timescale 1ns/1ps
module tb_calc_display;
    localparam int unsigned P = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] status = 2'b01;
    logic [3:0] data = 4'd0;
    logic [3:0] pos = 4'd0;
    logic [7:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       fd_a, fd_b, err_a, err_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] shadow_m [8];
    logic [3:0] disp_m   [8];
    logic       err_m;
    logic [1:0] prev_m;
    logic [6:0] q_a [$];
    logic [6:0] q_b [$];

    calc_display #(.PRESCALE(P), .BLANK_LZ(1)) u_a (
        .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
        .an(an_a), .seg(seg_a), .frame_done(fd_a), .err(err_a));
    calc_display #(.PRESCALE(P), .BLANK_LZ(0)) u_b (
        .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
        .an(an_b), .seg(seg_b), .frame_done(fd_b), .err(err_b));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40; 4'd1: return 7'h79; 4'd2: return 7'h24; 4'd3: return 7'h30;
            4'd4: return 7'h19; 4'd5: return 7'h12; 4'd6: return 7'h02; 4'd7: return 7'h78;
            4'd8: return 7'h00; 4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int d, input bit lz, input bit e);
        bit all_zero;
        if (e) begin
            case (d)
                0: return 7'h23;
                1, 2: return 7'h2F;
                3: return 7'h06;
                default: return 7'h7F;
            endcase
        end
        all_zero = 1'b1;
        for (int j = d; j < 8; j++) if (disp_m[j] != 4'd0) all_zero = 1'b0;
        if (lz && d > 0 && all_zero) return 7'h7F;
        return seg_of(disp_m[d]);
    endfunction

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1; status = 2'b01; pos = 4'd0; data = 4'd0;
        repeat (3) @(negedge clock);
        check("rst an", 32'(an_a), 32'hFF);
        check("rst seg", 32'(seg_a), 32'h7F);
        check("rst fd", 32'(fd_a), 32'h0);
        check("rst err", 32'(err_a), 32'h0);
        for (int i = 0; i < 8; i++) begin shadow_m[i] = '0; disp_m[i] = '0; end
        err_m = 1'b0; prev_m = 2'b01;
        reset = 1'b0;
    endtask

    // One cycle of stimulus; the reference model advances alongside it.
    task automatic drive(input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
        @(negedge clock);
        status = st; pos = p; data = d;
        if (!err_m) begin
            if (st == 2'b01 && p < 4'd8) shadow_m[p[2:0]] = d;
            if (st == 2'b10 && prev_m != 2'b10)
                for (int i = 0; i < 8; i++) disp_m[i] = shadow_m[i];
            if (st == 2'b00) err_m = 1'b1;
        end
        prev_m = st;
    endtask

    task automatic check_frame(input string tag);
        logic [7:0] ea;
        logic [6:0] ex;
        repeat (2) @(negedge clock);
        for (int d = 0; d < 8; d++) begin
            q_a.push_back(exp_seg(d, 1'b1, err_m));
            q_b.push_back(exp_seg(d, 1'b0, err_m));
        end
        check($sformatf("%s err", tag), 32'(err_a), 32'(err_m));
        for (int d = 0; d < 8; d++) begin
            ea = ~(8'd1 << d);
            for (int c = 0; c < 100 && an_a !== ea; c++) @(negedge clock);
            check($sformatf("%s an%0d", tag, d), 32'(an_a), 32'(ea));
            check($sformatf("%s an_b%0d", tag, d), 32'(an_b), 32'(ea));
            ex = q_a.pop_front();
            check($sformatf("%s seg%0d", tag, d), 32'(seg_a), 32'(ex));
            ex = q_b.pop_front();
            check($sformatf("%s seg_nolz%0d", tag, d), 32'(seg_b), 32'(ex));
        end
    endtask

    initial begin
        int first_fd, second_fd, nfd;
        apply_reset();
        first_fd = 0; second_fd = 0; nfd = 0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clock);
            if (c == 1) check("scan an c1", 32'(an_a), 32'hFE);
            if (c == 1) check("scan seg c1", 32'(seg_a), 32'h40);
            if (c == 5) check("scan an c5", 32'(an_a), 32'hFD);
            if (c == 5) check("scan seg c5", 32'(seg_a), 32'h7F);
            if (fd_a) begin
                nfd++;
                if (nfd == 1) first_fd = c;
                if (nfd == 2) second_fd = c;
            end
        end
        check("fd first", 32'(first_fd), 32'd32);
        check("fd second", 32'(second_fd), 32'd64);
        check("fd count", 32'(nfd), 32'd2);
        check_frame("zero");

        drive(2'b01, 4'd0, 4'd3); drive(2'b01, 4'd1, 4'd2); drive(2'b01, 4'd2, 4'd1);
        check_frame("busy_nocommit");
        drive(2'b10, 4'd0, 4'd0);
        check_frame("c123");

        drive(2'b01, 4'd0, 4'd5);
        check_frame("hold123");
        drive(2'b10, 4'd0, 4'd0); drive(2'b10, 4'd0, 4'd0);
        check_frame("c125");

        drive(2'b01, 4'd9, 4'd7); drive(2'b10, 4'd0, 4'd0);
        check_frame("pos9");

        drive(2'b01, 4'd0, 4'hC); drive(2'b01, 4'd3, 4'd4); drive(2'b01, 4'd2, 4'd0);
        drive(2'b10, 4'd0, 4'd0);
        check_frame("lz_mid");

        drive(2'b00, 4'd0, 4'd0);
        drive(2'b10, 4'd0, 4'd0);
        check("err set", 32'(err_a), 32'h1);
        check_frame("erro");
        drive(2'b01, 4'd0, 4'd8); drive(2'b01, 4'd7, 4'd9); drive(2'b10, 4'd0, 4'd0);
        drive(2'b01, 4'd0, 4'd0);
        check_frame("err_hold");

        apply_reset();
        @(negedge clock);
        check("post rst err", 32'(err_a), 32'h0);
        check_frame("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/calc_display.md
Name: calc_display

Overview:
- Downstream display stage for the calculator core. It consumes the serial digit stream (status, data, pos) and keeps an 8-digit frame buffer.
- It time-multiplexes the frame onto eight common-anode 7-segment displays, with leading-zero blanking and a latched error pattern.
- It sits between the calculator core and the board display pins.

Parameters:
- PRESCALE, 50000: clock cycles per scan slot (one digit lit per slot); legal range ≥ 2.
- BLANK_LZ, 1: 1 enables leading-zero blanking; 0 shows all eight digits.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- status  in  2  core status: 00 error, 01 busy (digits streaming), 10 ready
- data  in  4  BCD digit value for position pos
- pos  in  4  digit index 0..7 (0 = least significant); values 8..15 are ignored
- an  out  8  anode enables, active-low, one-hot-zero
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- frame_done  out  1  one-cycle pulse when the scan wraps from digit 7 to digit 0
- err  out  1  sticky error flag

Behaviour:

Reset (synchronous, priority over everything):
- an=8'hFF, seg=7'h7F, frame_done=0, err=0.
- Shadow and display banks zero; scan index 0; prescale counter 0; prev_status=01.

Capture:
- Each cycle with status==01 and pos≤7: shadow[pos] <= data.
- pos≥8 writes nothing.
- Repeated writes to the same pos: last write wins.

Commit:
- Trigger is a rising edge into ready: status==10 and prev_status!=10.
- On that cycle, display bank <= shadow (all 8 digits at once).
- prev_status is registered every cycle.
- A capture on the same cycle as a commit cannot occur, because the status values differ.
- The shadow bank is not cleared on commit.

Error:
- status==00 sets err=1 on the next edge. err then holds until reset, whatever status does later.
- While err=1, capture and commit are suppressed.
- While err=1, the display shows "Erro" on digits 3..0 and blanks digits 7..4. Segment codes: E=7'b0000110, r=7'b0101111, o=7'b0100011, blank=7'h7F.

Decode (active-low):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Values 10..15 decode to blank.

Leading-zero blanking (BLANK_LZ=1):
- Digit i is blanked if digit i and every digit above it are zero, for i≥1.
- Digit 0 is always shown, so an all-zero frame displays "0".
- Blanked digits drive seg=7'h7F with their anode still enabled.

Scan:
- The prescale counter counts 0..PRESCALE-1 and wraps.
- The tick is asserted when the counter equals PRESCALE-1.
- On each tick the index increments modulo 8. On the tick where the index goes 7→0, frame_done=1 for exactly one cycle.
- an and seg are registered. They reflect the index and the display bank with one-cycle latency, i.e. the cycle after the index changes.
- an has exactly one bit low: an[index]=0.
- A commit mid-frame takes effect from the next output update. There is no tearing protection.

State summary:
- NORMAL → ERROR on status==00.
- ERROR → NORMAL only via reset.

Test Plan:
1. Reset release with PRESCALE=4: after the first tick, an=8'hFE and seg=7'b1000000 ("0"); digits 1..7 blank; frame_done pulses every 32 cycles.
2. Stream pos0=3, pos1=2, pos2=1 with status=01, then status=10 → display bank = 00000123; digits 2,1,0 show 1,2,3; digits 7..3 seg=7'h7F.
3. With BLANK_LZ=0, repeat scenario 2 → digits 7..3 show "0" (seg=7'b1000000).
4. Stream while status stays 01 with no transition to 10 → the displayed value is unchanged until the 10 edge; a second 10 cycle without an intervening non-10 cycle does not re-commit.
5. Drive status=00 for one cycle, then 10 → err=1 and stays 1; digits 3..0 show E,r,r,o; further streams and commits are ignored; reset clears err and shows "0".
6. Write pos=9, data=7 during busy, then commit → display bank unchanged. Write data=4'hC at pos0, then commit → digit 0 seg=7'h7F.
